hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_sb_match.sv | 23 ++
 rtl/register.sv | 21 ++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 tb/tb_hazard_scoreboard.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the decode-stage hazard scoreboard.
// Stage indices, entry layout and register-index width.
package hazard_scoreboard_pkg;

  localparam int REG_W    = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  // One in-flight destination; 'rd' holds the destination register index.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one source register against the EX/MEM/WB scoreboard entries.
// Purely combinational; the WB entry is ignored when the register file bypasses.
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  sb_entry_t [SB_DEPTH-1:0] sb_i,
  input  logic      [REG_W-1:0]    reg_i,
  output logic                     match_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = sb_i[SB_EX].valid  && (sb_i[SB_EX].rd  == reg_i);
  assign mem_hit = sb_i[SB_MEM].valid && (sb_i[SB_MEM].rd == reg_i);
  assign wb_hit  = WB_BYPASS ? 1'b0 : (sb_i[SB_WB].valid && (sb_i[SB_WB].rd == reg_i));

  assign match_o = ex_hit | mem_hit | wb_hit;

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-high reset to zero.
// One cycle latency; holds its value while wr_en_i is low.
module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (wr_en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard, bubble and flush control with a 3-entry destination scoreboard.
// Control outputs are combinational; scoreboard, halt flag and stall counter update on clk.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] rs_sel,
  input  logic             rs_used,
  input  logic [REG_W-1:0] rt_sel,
  input  logic             rt_used,
  input  logic             dec_RegWrite,
  input  logic [REG_W-1:0] dec_Write_Register,
  input  logic             dec_Halt,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             Stall,
  output logic             id_ex_Bubble,
  output logic             if_id_Flush,
  output logic             halted,
  output logic [15:0]      stall_cycles
);

  sb_entry_t [SB_DEPTH-1:0] sb_q;
  sb_entry_t [SB_DEPTH-1:0] sb_d;
  logic                     halted_q;
  logic                     halted_d;
  logic [15:0]              stall_cycles_q;
  logic [15:0]              stall_cycles_d;
  logic                     rs_match;
  logic                     rt_match;
  logic                     hazard;
  logic                     issue;
  logic                     count_en;

  sb_match #(.WB_BYPASS(WB_BYPASS)) u_rs_match (
    .sb_i    (sb_q),
    .reg_i   (rs_sel),
    .match_o (rs_match)
  );

  sb_match #(.WB_BYPASS(WB_BYPASS)) u_rt_match (
    .sb_i    (sb_q),
    .reg_i   (rt_sel),
    .match_o (rt_match)
  );

  assign hazard = dec_valid & ((rs_used & rs_match) | (rt_used & rt_match));
  assign issue  = dec_valid & ~mem_stall & ~halted_q & ~ex_redirect & ~hazard;

  // A redirect makes the ID instruction wrong-path, so it is squashed rather than held.
  assign Stall        = mem_stall | halted_q | (hazard & ~ex_redirect);
  assign id_ex_Bubble = ~mem_stall & (halted_q | ex_redirect | hazard | ~dec_valid);
  assign if_id_Flush  = ex_redirect & ~mem_stall & ~halted_q;

  always_comb begin
    sb_d               = sb_q;
    sb_d[SB_WB]        = sb_q[SB_MEM];
    sb_d[SB_MEM]       = sb_q[SB_EX];
    sb_d[SB_EX].valid  = issue & dec_RegWrite;
    sb_d[SB_EX].rd     = dec_Write_Register;
  end

  register #(.W($bits(sb_q))) u_sb (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (~mem_stall),
    .d_i     (sb_d),
    .q_o     (sb_q)
  );

  assign count_en = hazard & ~ex_redirect & ~mem_stall & ~halted_q;

  always_comb begin
    halted_d       = halted_q | (issue & dec_Halt);
    stall_cycles_d = stall_cycles_q;
    if (count_en && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q       <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      halted_q       <= halted_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign halted       = halted_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance with WB bypass, one without,
// both driven by the same decode stream.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [2:0]  rs_sel;
  logic        rs_used;
  logic [2:0]  rt_sel;
  logic        rt_used;
  logic        dec_RegWrite;
  logic [2:0]  dec_Write_Register;
  logic        dec_Halt;
  logic        ex_redirect;
  logic        mem_stall;

  logic        stall1, bub1, flush1, halt1;
  logic [15:0] cnt1;
  logic        stall0, bub0, flush0, halt0;
  logic [15:0] cnt0;

  int n_total;
  int n_pass;
  int n_fail;

  hazard_scoreboard #(.WB_BYPASS(1'b1)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .dec_valid          (dec_valid),
    .rs_sel             (rs_sel),
    .rs_used            (rs_used),
    .rt_sel             (rt_sel),
    .rt_used            (rt_used),
    .dec_RegWrite       (dec_RegWrite),
    .dec_Write_Register (dec_Write_Register),
    .dec_Halt           (dec_Halt),
    .ex_redirect        (ex_redirect),
    .mem_stall          (mem_stall),
    .Stall              (stall1),
    .id_ex_Bubble       (bub1),
    .if_id_Flush        (flush1),
    .halted             (halt1),
    .stall_cycles       (cnt1)
  );

  hazard_scoreboard #(.WB_BYPASS(1'b0)) u_dut0 (
    .clk                (clk),
    .rst                (rst),
    .dec_valid          (dec_valid),
    .rs_sel             (rs_sel),
    .rs_used            (rs_used),
    .rt_sel             (rt_sel),
    .rt_used            (rt_used),
    .dec_RegWrite       (dec_RegWrite),
    .dec_Write_Register (dec_Write_Register),
    .dec_Halt           (dec_Halt),
    .ex_redirect        (ex_redirect),
    .mem_stall          (mem_stall),
    .Stall              (stall0),
    .id_ex_Bubble       (bub0),
    .if_id_Flush        (flush0),
    .halted             (halt0),
    .stall_cycles       (cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input int v, input int rs, input int rsu, input int rt, input int rtu,
                       input int rw, input int wr, input int hlt);
    dec_valid          = v[0];
    rs_sel             = rs[2:0];
    rs_used            = rsu[0];
    rt_sel             = rt[2:0];
    rt_used            = rtu[0];
    dec_RegWrite       = rw[0];
    dec_Write_Register = wr[2:0];
    dec_Halt           = hlt[0];
  endtask

  task automatic idle(input int n);
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst         = 1'b1;
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_stall",  32'(stall1), 0);
    chk("reset_bubble", 32'(bub1),   1);
    chk("reset_flush",  32'(flush1), 0);
    chk("reset_halted", 32'(halt1),  0);
    chk("reset_cnt",    32'(cnt1),   0);
    chk("reset_cnt_nb", 32'(cnt0),   0);

    // Back-to-back RAW on r3
    instr(1, 0, 0, 0, 0, 1, 3, 0);
    #1;
    chk("raw_prod_stall",  32'(stall1), 0);
    chk("raw_prod_bubble", 32'(bub1),   0);
    step();
    instr(1, 3, 1, 0, 0, 1, 6, 0);
    #1;
    chk("raw_c1_stall",  32'(stall1), 1);
    chk("raw_c1_bubble", 32'(bub1),   1);
    step();
    chk("raw_c2_stall",  32'(stall1), 1);
    chk("raw_c2_bubble", 32'(bub1),   1);
    step();
    chk("raw_c3_issue_stall",  32'(stall1), 0);
    chk("raw_c3_issue_bubble", 32'(bub1),   0);
    chk("raw_c3_nobypass",     32'(stall0), 1);
    step();
    chk("raw_cnt",    32'(cnt1), 2);
    chk("raw_cnt_nb", 32'(cnt0), 3);
    idle(4);

    // Independent ops, then consumer one behind its producer
    instr(1, 0, 0, 0, 0, 1, 3, 0);
    step();
    instr(1, 4, 1, 5, 1, 0, 0, 0);
    #1;
    chk("indep_stall",    32'(stall1), 0);
    chk("indep_stall_nb", 32'(stall0), 0);
    step();
    instr(1, 0, 0, 3, 1, 0, 0, 0);
    #1;
    chk("behind_c1_stall", 32'(stall1), 1);
    step();
    chk("behind_c2_stall",    32'(stall1), 0);
    chk("behind_c2_stall_nb", 32'(stall0), 1);
    step();
    chk("behind_cnt",    32'(cnt1), 3);
    chk("behind_cnt_nb", 32'(cnt0), 5);
    idle(4);

    // r0 is tracked like any other register
    instr(1, 0, 0, 0, 0, 1, 0, 0);
    step();
    instr(1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("r0_match", 32'(stall1), 1);
    idle(4);

    // Redirect while a hazard is pending
    instr(1, 0, 0, 0, 0, 1, 1, 0);
    step();
    instr(1, 1, 1, 0, 0, 1, 7, 0);
    ex_redirect = 1'b1;
    #1;
    chk("redir_stall",    32'(stall1), 0);
    chk("redir_bubble",   32'(bub1),   1);
    chk("redir_flush",    32'(flush1), 1);
    chk("redir_stall_nb", 32'(stall0), 0);
    step();
    ex_redirect = 1'b0;
    instr(1, 7, 1, 0, 0, 0, 0, 0);
    #1;
    chk("redir_ex_invalid", 32'(stall1), 0);
    chk("redir_flush_off",  32'(flush1), 0);
    step();
    chk("redir_cnt", 32'(cnt1), 3);
    idle(4);

    // Memory stall freezes everything with r2 in MEM
    instr(1, 0, 0, 0, 0, 1, 2, 0);
    step();
    idle(1);
    instr(1, 2, 1, 0, 0, 0, 0, 0);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("memstall_stall",  32'(stall1), 1);
      chk("memstall_bubble", 32'(bub1),   0);
      step();
    end
    chk("memstall_cnt_hold",    32'(cnt1), 3);
    chk("memstall_cnt_hold_nb", 32'(cnt0), 5);
    mem_stall = 1'b0;
    #1;
    chk("memstall_sb_held",  32'(stall1), 1);
    chk("memstall_release_bubble", 32'(bub1), 1);
    step();
    chk("memstall_wb_stall",    32'(stall1), 0);
    chk("memstall_wb_stall_nb", 32'(stall0), 1);
    step();
    chk("memstall_cnt",    32'(cnt1), 4);
    chk("memstall_cnt_nb", 32'(cnt0), 7);
    idle(4);

    // HALT
    instr(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("halt_issue_stall", 32'(stall1), 0);
    chk("halt_pre",         32'(halt1),  0);
    step();
    chk("halt_set",    32'(halt1), 1);
    chk("halt_set_nb", 32'(halt0), 1);
    instr(1, 0, 0, 0, 0, 1, 5, 0);
    ex_redirect = 1'b1;
    #1;
    chk("halt_stall",  32'(stall1), 1);
    chk("halt_bubble", 32'(bub1),   1);
    chk("halt_flush",  32'(flush1), 0);
    repeat (3) step();
    chk("halt_stall_late",  32'(stall1), 1);
    chk("halt_bubble_late", 32'(bub1),   1);
    chk("halt_sticky",      32'(halt1),  1);
    chk("halt_cnt",         32'(cnt1),   4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_redirect = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("halt_rst_halted", 32'(halt1),  0);
    chk("halt_rst_stall",  32'(stall1), 0);
    chk("halt_rst_bubble", 32'(bub1),   1);
    chk("halt_rst_flush",  32'(flush1), 0);
    chk("halt_rst_cnt",    32'(cnt1),   0);
    chk("halt_rst_cnt_nb", 32'(cnt0),   0);

    // Saturation: self-dependent r1 stream stalls 3 of 4 cycles without bypass
    instr(1, 1, 1, 0, 0, 1, 1, 0);
    repeat (87400) @(posedge clk);
    #1;
    chk("sat_cnt_nb", 32'(cnt0), 32'hFFFF);
    chk("sat_cnt",    32'(cnt1), 58266);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_midstall_cnt",    32'(cnt1),   0);
    chk("rst_midstall_cnt_nb", 32'(cnt0),   0);
    chk("rst_midstall_stall",  32'(stall1), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
